fft_ctrl: RTL and testbench
===========================

FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 Parameter N_LOG2, default 3; log2 of FFT length N, range 2..10.
REQ-002 Parameter PIPE_LAT, default 2; butterfly datapath latency in cycles from issue to write-back, range 1..8.
REQ-003 Reset is synchronous and active-high; the block uses one clock.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 i_start  input  1  request to run one in-place FFT pass; sampled only in IDLE.
REQ-007 i_stall  input  1  freezes butterfly issue while high in RUN.
REQ-008 o_busy  output  1  high in every state other than IDLE.
REQ-009 o_done  output  1  one-cycle pulse when the transform is complete.
REQ-010 o_stage  output  clog2(N_LOG2)  current stage index s.
REQ-011 o_bf_valid  output  1  a butterfly read is issued this cycle.
REQ-012 o_addr_a / o_addr_b  output  N_LOG2 each  read addresses of the butterfly operand pair.
REQ-013 o_tw_addr  output  N_LOG2-1  twiddle ROM address.
REQ-014 o_wr_valid  output  1  write-back strobe for the butterfly results.
REQ-015 o_wr_addr_a / o_wr_addr_b  output  N_LOG2 each  write-back addresses.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-017 FSM transitions:
- IDLE->RUN on i_start.
- RUN->DRAIN after N/2 issued butterflies.
- DRAIN->RUN after PIPE_LAT cycles, if s<N_LOG2-1; s then increments and the butterfly index k clears.
- DRAIN->DONE after PIPE_LAT cycles, if s=N_LOG2-1.
- DONE->IDLE unconditionally after one cycle.
REQ-018 In RUN with i_stall=0:
- o_bf_valid=1.
- One butterfly is issued per cycle.
- k increments 0..N/2-1.
REQ-019 In RUN with i_stall=1:
- o_bf_valid=0.
- k, s and the FSM state hold.
- The write-back delay line keeps shifting.
REQ-020 Address generation, with span=2^s, group j=k>>s, position p=k&(span-1):
- o_addr_a=(j<<(s+1))|p.
- o_addr_b=o_addr_a+span.
- o_tw_addr=p<<(N_LOG2-1-s), truncated to N_LOG2-1 bits.
REQ-021 Address outputs:
- Address outputs are registered and valid in the same cycle as o_bf_valid.
- Their value is don't-care when o_bf_valid=0.
REQ-022 Write-back delay line:
- o_wr_valid, o_wr_addr_a and o_wr_addr_b are copies of o_bf_valid, o_addr_a and o_addr_b delayed exactly PIPE_LAT cycles.
- The delay line shifts every cycle regardless of state or stall.
REQ-023 DRAIN guarantees that the last write-back of stage s occurs no later than the cycle before the first read of stage s+1.
REQ-024 Stall timing: with no stall, i_start sampled at cycle 0 gives:
- First issue at cycle 1.
- o_done at cycle N_LOG2*(N/2+PIPE_LAT)+1.
- Each stall cycle adds exactly one cycle of latency.
REQ-025 i_start is ignored while o_busy=1; a new pass needs a fresh i_start in IDLE.
REQ-026 i_start asserted in the DONE cycle is ignored.
REQ-027 o_done=1 only in DONE; o_busy=1 in DONE.
REQ-028 o_stage holds its last value in IDLE and clears to 0 on entry to RUN from IDLE.

Reset
REQ-029 While rst=1 on a clock edge, the following take effect on that edge regardless of state:
- FSM=IDLE; k=0; s=0.
- o_busy, o_done, o_bf_valid and o_wr_valid are 0.
- All address outputs are 0.
- The delay-line contents are cleared.
REQ-030 Reset mid-operation aborts the pass; no o_wr_valid is asserted after the reset edge until a new pass issues butterflies.
REQ-031 rst has priority over i_start in the same cycle.

Verification
REQ-032 N_LOG2=3, PIPE_LAT=2, pulse i_start, no stall: required responses are:
- Stage 0 issues (a,b,tw) = (0,1,0),(2,3,0),(4,5,0),(6,7,0).
- Stage 1 issues (0,2,0),(1,3,2),(4,6,0),(5,7,2).
- Stage 2 issues (0,4,0),(1,5,1),(2,6,2),(3,7,3).
- o_done is a single pulse at cycle 19.
REQ-033 Same setup, i_stall=1 for 3 cycles mid-stage 1: the issue sequence is unchanged and o_done occurs at cycle 22.
REQ-034 Same setup, check write-back timing: every o_wr_valid occurs 2 cycles after its o_bf_valid with matching addresses, and the last stage-s write precedes the first stage-s+1 read.
REQ-035 Same setup, rst asserted at cycle 9, then pulse i_start at cycle 12: required responses are:
- All outputs are 0 at cycle 10.
- No o_wr_valid occurs in cycles 10..12.
- The pass restarts from stage 0, k=0.
REQ-036 Same setup, i_start held high continuously: o_done pulses every 21 cycles (19 plus the DONE->IDLE->RUN cycles), and i_start is never accepted while o_busy=1.
REQ-037 N_LOG2=2, PIPE_LAT=1: required responses are:
- The issue sequence is (0,1,0),(2,3,0),(0,2,0),(1,3,1).
- o_done occurs at cycle 7.

Source files
------------

// File: rtl/fft_ctrl.sv
// rtl/fft_ctrl.sv - In-place radix-2 FFT sequencing and address generation controller
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   i_start           start one in-place pass (honoured only in IDLE)
//   i_stall           hold butterfly issue while in RUN
//   o_busy            high whenever the controller is not IDLE
//   o_done            one-cycle completion pulse (DONE state)
//   o_stage           current stage index s
//   o_bf_valid        butterfly operand read issued this cycle
//   o_addr_a/b        operand pair read addresses
//   o_tw_addr         twiddle ROM address
//   o_wr_valid        write-back strobe, o_bf_valid delayed PIPE_LAT cycles
//   o_wr_addr_a/b     write-back addresses, o_addr_a/b delayed PIPE_LAT cycles

module fft_ctrl #(
    parameter int N_LOG2   = 3,
    parameter int PIPE_LAT = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic                        i_stall,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [$clog2(N_LOG2)-1:0]   o_stage,
    output logic                        o_bf_valid,
    output logic [N_LOG2-1:0]           o_addr_a,
    output logic [N_LOG2-1:0]           o_addr_b,
    output logic [N_LOG2-2:0]           o_tw_addr,
    output logic                        o_wr_valid,
    output logic [N_LOG2-1:0]           o_wr_addr_a,
    output logic [N_LOG2-1:0]           o_wr_addr_b
);

    localparam int SW = $clog2(N_LOG2);
    localparam int KW = N_LOG2 - 1;
    localparam int CW = $clog2(PIPE_LAT + 1);

    localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
    localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [SW-1:0]   s;
    logic [CW-1:0]   cnt;

    // Issue-side address computation. In DRAIN the only issue that can
    // happen is the first butterfly of the next stage, issued on the same
    // edge that leaves DRAIN, so the operands are taken as (k=0, s+1).
    logic [KW-1:0]     iss_k;
    logic [SW-1:0]     iss_s;
    logic [KW-1:0]     mask_k;
    logic [KW-1:0]     pos_k;
    logic [N_LOG2-1:0] iss_a;
    logic [N_LOG2-1:0] iss_b;
    logic [KW-1:0]     iss_tw;
    int                tw_sh;

    always_comb begin
        iss_k = k;
        iss_s = s;
        if (state == DRAIN) begin
            iss_k = '0;
            iss_s = s + SW'(1);
        end
        // span-1 mask; wraps to all ones on the last stage where span = N/2
        mask_k = (KW'(1) << iss_s) - KW'(1);
        pos_k  = iss_k & mask_k;
        // (j << (s+1)) | p  ==  ((k with low s bits cleared) << 1) | p
        iss_a  = {iss_k & ~mask_k, 1'b0} | {1'b0, pos_k};
        // bit s of iss_a is always clear, so OR is the same as adding span
        iss_b  = iss_a | (N_LOG2'(1) << iss_s);
        tw_sh  = KW - int'(iss_s);
        iss_tw = pos_k << tw_sh;
    end

    assign o_stage = s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            s          <= '0;
            cnt        <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_bf_valid <= 1'b0;
            o_addr_a   <= '0;
            o_addr_b   <= '0;
            o_tw_addr  <= '0;
        end else begin
            o_bf_valid <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= RUN;
                        o_busy <= 1'b1;
                        k      <= '0;
                        s      <= '0;
                    end
                end
                RUN: begin
                    if (!i_stall) begin
                        o_bf_valid <= 1'b1;
                        o_addr_a   <= iss_a;
                        o_addr_b   <= iss_b;
                        o_tw_addr  <= iss_tw;
                        k          <= k + KW'(1);
                        if (k == K_LAST) begin
                            state <= DRAIN;
                            cnt   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // DRAIN spans the cycle showing the last issue plus
                    // PIPE_LAT quiet cycles, so the last write-back lands
                    // before the next stage's first read.
                    if (cnt == CW'(PIPE_LAT)) begin
                        if (s == S_LAST) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= RUN;
                            s     <= iss_s;
                            k     <= '0;
                            if (!i_stall) begin
                                o_bf_valid <= 1'b1;
                                o_addr_a   <= iss_a;
                                o_addr_b   <= iss_b;
                                o_tw_addr  <= iss_tw;
                                k          <= KW'(1);
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-back delay line: free-running, independent of state and stall.
    logic [PIPE_LAT-1:0]             dl_v;
    logic [PIPE_LAT-1:0][N_LOG2-1:0] dl_a;
    logic [PIPE_LAT-1:0][N_LOG2-1:0] dl_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            dl_v <= '0;
            dl_a <= '0;
            dl_b <= '0;
        end else begin
            dl_v[0] <= o_bf_valid;
            dl_a[0] <= o_addr_a;
            dl_b[0] <= o_addr_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_a[i] <= dl_a[i-1];
                dl_b[i] <= dl_b[i-1];
            end
        end
    end

    assign o_wr_valid  = dl_v[PIPE_LAT-1];
    assign o_wr_addr_a = dl_a[PIPE_LAT-1];
    assign o_wr_addr_b = dl_b[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_ctrl.sv
// tb/tb_fft_ctrl.sv - Directed self-checking bench for fft_ctrl

module tb_fft_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, stall;
    logic       a_busy, a_done, a_bf_valid, a_wr_valid;
    logic [1:0] a_stage, a_tw;
    logic [2:0] a_addr_a, a_addr_b, a_wr_a, a_wr_b;

    logic       rst2, start2, stall2;
    logic       b_busy, b_done, b_bf_valid, b_wr_valid;
    logic       b_stage, b_tw;
    logic [1:0] b_addr_a, b_addr_b, b_wr_a, b_wr_b;

    fft_ctrl #(.N_LOG2(3), .PIPE_LAT(2)) u_a (
        .clk(clk), .rst(rst), .i_start(start), .i_stall(stall),
        .o_busy(a_busy), .o_done(a_done), .o_stage(a_stage),
        .o_bf_valid(a_bf_valid), .o_addr_a(a_addr_a), .o_addr_b(a_addr_b),
        .o_tw_addr(a_tw), .o_wr_valid(a_wr_valid),
        .o_wr_addr_a(a_wr_a), .o_wr_addr_b(a_wr_b)
    );

    fft_ctrl #(.N_LOG2(2), .PIPE_LAT(1)) u_b (
        .clk(clk), .rst(rst2), .i_start(start2), .i_stall(stall2),
        .o_busy(b_busy), .o_done(b_done), .o_stage(b_stage),
        .o_bf_valid(b_bf_valid), .o_addr_a(b_addr_a), .o_addr_b(b_addr_b),
        .o_tw_addr(b_tw), .o_wr_valid(b_wr_valid),
        .o_wr_addr_a(b_wr_a), .o_wr_addr_b(b_wr_b)
    );

    int checks = 0;
    int errors = 0;

    int ta[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int tb[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int ttw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    int ba[4]   = '{0, 2, 0, 1};
    int bb[4]   = '{1, 3, 2, 3};
    int btw[4]  = '{0, 0, 0, 1};
    int bcyc[4] = '{1, 2, 4, 5};

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full pass on instance A. Cycle 0 is the cycle after the edge
    // that samples i_start; stall is driven during cycles
    // [st_from, st_from+st_len) and delays every later issue by st_len.
    task automatic run_pass(input int done_cyc, input int st_from, input int st_len);
        int n, m, u;
        int hv[64];
        int ha[64];
        int hb[64];
        int last_wr[3];
        int first_rd[3];
        n = 0;
        m = 0;
        for (int i = 0; i < 3; i++) begin
            last_wr[i]  = 0;
            first_rd[i] = 0;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c <= done_cyc + 1; c++) begin
            stall = (c >= st_from && c < st_from + st_len);
            @(negedge clk);
            hv[c] = int'(a_bf_valid);
            ha[c] = int'(a_addr_a);
            hb[c] = int'(a_addr_b);
            if (a_bf_valid) begin
                if (n < 12) begin
                    u = 1 + (n / 4) * 6 + n % 4;
                    if (st_len > 0 && u > st_from) u += st_len;
                    chk("issue_cycle", c, u);
                    chk("addr_a", int'(a_addr_a), ta[n]);
                    chk("addr_b", int'(a_addr_b), tb[n]);
                    chk("tw_addr", int'(a_tw), ttw[n]);
                    chk("stage", int'(a_stage), n / 4);
                    if (n % 4 == 0) first_rd[n / 4] = c;
                end
                n++;
            end
            chk("wr_valid", int'(a_wr_valid), (c >= 2) ? hv[c-2] : 0);
            if (a_wr_valid && c >= 2) begin
                chk("wr_addr_a", int'(a_wr_a), ha[c-2]);
                chk("wr_addr_b", int'(a_wr_b), hb[c-2]);
                if (m < 12) last_wr[m / 4] = c;
                m++;
            end
            chk("done", int'(a_done), int'(c == done_cyc));
            chk("busy", int'(a_busy), int'(c <= done_cyc));
            step();
        end
        stall = 1'b0;
        chk("issue_count", n, 12);
        chk("wr_count", m, 12);
        chk("drain_order_0_1", int'(last_wr[0] < first_rd[1]), 1);
        chk("drain_order_1_2", int'(last_wr[1] < first_rd[2]), 1);
    endtask

    initial begin
        int dcnt, nb;
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        rst2 = 1'b1; start2 = 1'b0; stall2 = 1'b0;
        step();
        step();
        rst = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_done", int'(a_done), 0);
        chk("rst_bf_valid", int'(a_bf_valid), 0);
        chk("rst_wr_valid", int'(a_wr_valid), 0);
        chk("rst_addr_a", int'(a_addr_a), 0);
        chk("rst_stage", int'(a_stage), 0);
        chk("rst_b_busy", int'(b_busy), 0);
        step();

        // plain pass, then a pass with a 3-cycle stall in stage 1
        run_pass(19, 0, 0);
        run_pass(22, 8, 3);

        // reset in the middle of stage 1, restart afterwards
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(a_busy), 0);
        chk("midrst_done", int'(a_done), 0);
        chk("midrst_bf_valid", int'(a_bf_valid), 0);
        chk("midrst_wr_valid", int'(a_wr_valid), 0);
        chk("midrst_addr_a", int'(a_addr_a), 0);
        chk("midrst_addr_b", int'(a_addr_b), 0);
        chk("midrst_tw", int'(a_tw), 0);
        chk("midrst_wr_a", int'(a_wr_a), 0);
        chk("midrst_wr_b", int'(a_wr_b), 0);
        chk("midrst_stage", int'(a_stage), 0);
        for (int c = 11; c <= 12; c++) begin
            step();
            @(negedge clk);
            chk("postrst_wr_valid", int'(a_wr_valid), 0);
            chk("postrst_busy", int'(a_busy), 0);
        end
        step();
        run_pass(19, 0, 0);

        // reset wins over a simultaneous start
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", int'(a_busy), 0);
        step();
        @(negedge clk);
        chk("rst_prio_busy2", int'(a_busy), 0);
        chk("rst_prio_bf", int'(a_bf_valid), 0);
        step();

        // start held high: back-to-back passes every 21 cycles
        dcnt = 0;
        start = 1'b1;
        step();
        for (int c = 0; c <= 62; c++) begin
            @(negedge clk);
            if (a_done) begin
                chk("held_done_cycle", c, 19 + 21 * dcnt);
                dcnt++;
            end
            if (c == 20) begin
                chk("held_idle_busy", int'(a_busy), 0);
                chk("held_idle_stage", int'(a_stage), 2);
            end
            if (c == 62) start = 1'b0;
            step();
        end
        @(negedge clk);
        chk("held_done_count", dcnt, 3);
        chk("held_end_busy", int'(a_busy), 0);
        chk("held_end_stage", int'(a_stage), 2);
        step();

        // N_LOG2=2, PIPE_LAT=1 instance
        nb = 0;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (b_bf_valid) begin
                if (nb < 4) begin
                    chk("b_issue_cycle", c, bcyc[nb]);
                    chk("b_addr_a", int'(b_addr_a), ba[nb]);
                    chk("b_addr_b", int'(b_addr_b), bb[nb]);
                    chk("b_tw_addr", int'(b_tw), btw[nb]);
                end
                nb++;
            end
            chk("b_done", int'(b_done), int'(c == 7));
            step();
        end
        chk("b_issue_count", nb, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
